ifetch_unit: RTL and testbench

Instruction fetch stage of the multi-cycle ARM core, directly upstream of the control FSM. Owns the PC register and the IR register, and runs a request/acknowledge handshake with a variable-latency instruction memory. It delivers a fetched word on `IR` with a one-cycle `W_IR_valid` pulse. It applies the FSM's PC-update commands (`write_pc`, `pc_s`) for sequential, BX-register and ALU-result (branch) targets.

---
 rtl/ifetch_unit_if.sv | 28 ++
 rtl/ifetch_unit.sv | 153 +++++++++++++++
 tb/tb_ifetch_unit.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_unit_if.sv
// Handshake and data bundle between the fetch stage, the control FSM and the
// instruction memory. "master" is the fetch unit's view.
interface ifetch_if;
  logic        write_ir;
  logic        write_pc;
  logic [1:0]  pc_s;
  logic [31:0] pc_from_b;
  logic [31:0] pc_from_f;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] IR;
  logic [31:0] PC;
  logic        W_IR_valid;
  logic        fetch_err;
  logic        misalign_err;

  modport master (
    input  write_ir, write_pc, pc_s, pc_from_b, pc_from_f, imem_ack, imem_rdata,
    output imem_req, imem_addr, IR, PC, W_IR_valid, fetch_err, misalign_err
  );

  modport slave (
    output write_ir, write_pc, pc_s, pc_from_b, pc_from_f, imem_ack, imem_rdata,
    input  imem_req, imem_addr, IR, PC, W_IR_valid, fetch_err, misalign_err
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns PC and IR, runs a req/ack handshake with a
// variable-latency instruction memory and applies PC redirects from the FSM.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 15
) (
  input logic      clk,
  input logic      rst,
  ifetch_if.master fetch_io
);

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] addr_q, addr_d;
  logic        req_q, req_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        merr_q, merr_d;
  logic        drop_q, drop_d;
  logic [7:0]  wait_q, wait_d;
  logic        redirect_s;
  logic [31:0] target_s;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  // Next-state logic: redirect decode, PC update and fetch handshake FSM.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    addr_d     = addr_q;
    req_d      = req_q;
    valid_d    = 1'b0;
    ferr_d     = ferr_q;
    merr_d     = merr_q;
    drop_d     = drop_q;
    wait_d     = wait_q;
    redirect_s = 1'b0;
    target_s   = fetch_io.pc_from_f;

    if (fetch_io.write_pc) begin
      case (fetch_io.pc_s)
        2'b01: begin
          redirect_s = 1'b1;
          target_s   = fetch_io.pc_from_b;
        end
        2'b10: begin
          redirect_s = 1'b1;
          target_s   = fetch_io.pc_from_f;
        end
        default: redirect_s = 1'b0;
      endcase
    end else begin
      redirect_s = 1'b0;
    end

    if (redirect_s) begin
      pc_d   = word_align(target_s);
      merr_d = merr_q | (target_s[1:0] != 2'b00);
    end else begin
      pc_d = pc_q;
    end

    case (state_q)
      S_IDLE: begin
        // A redirect on the launching edge makes the new target the fetch address.
        if (fetch_io.write_ir) begin
          state_d = S_REQ;
          req_d   = 1'b1;
          addr_d  = pc_d;
          wait_d  = 8'd0;
          drop_d  = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (fetch_io.imem_ack) begin
          req_d  = 1'b0;
          drop_d = 1'b0;
          if (drop_q || redirect_s) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
            ir_d    = fetch_io.imem_rdata;
            pc_d    = pc_q + 32'd4;
            valid_d = 1'b1;
          end
        end else if (wait_q == WAIT_LAST) begin
          req_d   = 1'b0;
          drop_d  = 1'b0;
          ferr_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_d = wait_q + 8'd1;
          drop_d = drop_q | redirect_s;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= 32'd0;
      addr_q  <= 32'd0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      merr_q  <= 1'b0;
      drop_q  <= 1'b0;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      merr_q  <= merr_d;
      drop_q  <= drop_d;
      wait_q  <= wait_d;
    end
  end

  assign fetch_io.imem_req     = req_q;
  assign fetch_io.imem_addr    = addr_q;
  assign fetch_io.IR           = ir_q;
  assign fetch_io.PC           = pc_q;
  assign fetch_io.W_IR_valid   = valid_q;
  assign fetch_io.fetch_err    = ferr_q;
  assign fetch_io.misalign_err = merr_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: a latency-programmable memory responder
// returns addr ^ salt, expected IR/PC are queued when each fetch is launched.
module tb_ifetch_unit;
  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  int          n_checks = 0;
  int          n_fail = 0;
  int          lat_cfg = 0;
  bit          ack_force = 1'b0;
  int          req_cnt = 0;
  logic [31:0] salt = 32'hE281_0001;
  exp_t        sb_q[$];

  ifetch_if bus();

  ifetch_unit #(.RESET_PC(32'h0000_0000), .MAX_WAIT(15)) dut (
    .clk(clk),
    .rst(rst),
    .fetch_io(bus)
  );

  always #5 clk = ~clk;

  // memory responder: acks on the (lat_cfg+1)-th request cycle, never if lat_cfg < 0
  always @(negedge clk) begin
    if (ack_force) bus.imem_ack = 1'b1;
    else if (bus.imem_req === 1'b1 && lat_cfg >= 0 && req_cnt == lat_cfg) bus.imem_ack = 1'b1;
    else bus.imem_ack = 1'b0;
    if (bus.imem_req === 1'b1) req_cnt++; else req_cnt = 0;
    bus.imem_rdata = bus.imem_addr ^ salt;
  end

  task automatic test_reset();
    rst = 1'b1;
    bus.write_ir = 1'b0; bus.write_pc = 1'b0; bus.pc_s = 2'b00;
    bus.pc_from_b = 32'd0; bus.pc_from_f = 32'd0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.PC !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want %h", bus.PC, 32'h0); end
    n_checks++;
    if ({bus.imem_req, bus.imem_addr, bus.IR, bus.W_IR_valid, bus.fetch_err, bus.misalign_err} !== 68'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: req=%b addr=%h ir=%h v=%b ferr=%b merr=%b want all 0",
               bus.imem_req, bus.imem_addr, bus.IR, bus.W_IR_valid, bus.fetch_err, bus.misalign_err);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.imem_req, bus.W_IR_valid, bus.PC} !== 34'd0) begin
      n_fail++; $display("FAIL idle_after_reset: req=%b v=%b pc=%h want 0", bus.imem_req, bus.W_IR_valid, bus.PC);
    end
  endtask

  task automatic test_zero_wait();
    bit seen = 1'b0; int at = 0; exp_t e;
    @(negedge clk);
    sb_q.push_back(exp_t'{ir: 32'hE281_0001, pc: 32'h4});
    lat_cfg = 0; bus.write_ir = 1'b1;
    for (int k = 1; k <= 10 && !seen; k++) begin
      @(negedge clk);
      if (bus.W_IR_valid) begin
        seen = 1'b1; at = k; bus.write_ir = 1'b0;
        e = sb_q.pop_front();
        n_checks++; if (bus.IR !== e.ir) begin n_fail++; $display("FAIL zw_ir: got %h want %h", bus.IR, e.ir); end
        n_checks++; if (bus.PC !== e.pc) begin n_fail++; $display("FAIL zw_pc: got %h want %h", bus.PC, e.pc); end
      end
    end
    n_checks++; if (at != 2) begin n_fail++; $display("FAIL zw_latency: got %0d want 2", at); end
    @(negedge clk);
    n_checks++; if (bus.W_IR_valid !== 1'b0) begin n_fail++; $display("FAIL zw_pulse_width: valid still %b", bus.W_IR_valid); end
  endtask

  task automatic test_latency();
    bit seen = 1'b0; int at = 0; int reqc = 0; bit addr_bad = 1'b0; exp_t e;
    @(negedge clk);
    sb_q.push_back(exp_t'{ir: 32'h4 ^ salt, pc: 32'h8});
    lat_cfg = 3; bus.write_ir = 1'b1;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      if (bus.imem_req) begin reqc++; if (bus.imem_addr !== 32'h4) addr_bad = 1'b1; end
      if (bus.W_IR_valid) begin
        seen = 1'b1; at = k; bus.write_ir = 1'b0;
        e = sb_q.pop_front();
        n_checks++; if (bus.IR !== e.ir) begin n_fail++; $display("FAIL lat_ir: got %h want %h", bus.IR, e.ir); end
        n_checks++; if (bus.PC !== e.pc) begin n_fail++; $display("FAIL lat_pc: got %h want %h", bus.PC, e.pc); end
      end
    end
    n_checks++; if (at != 5) begin n_fail++; $display("FAIL lat_valid_cycle: got %0d want 5", at); end
    n_checks++; if (reqc != 4) begin n_fail++; $display("FAIL lat_req_cycles: got %0d want 4", reqc); end
    n_checks++; if (addr_bad) begin n_fail++; $display("FAIL lat_addr_stable: got unstable want 00000004"); end
  endtask

  task automatic test_bx_redirect();
    bit seen = 1'b0; bit got_addr = 1'b0; logic [31:0] a1 = 32'hX; exp_t e;
    @(negedge clk);
    bus.write_pc = 1'b1; bus.pc_s = 2'b00;
    @(negedge clk);
    n_checks++; if (bus.PC !== 32'h8) begin n_fail++; $display("FAIL pcs00_hold: got %h want %h", bus.PC, 32'h8); end
    bus.pc_s = 2'b11; bus.pc_from_b = 32'h1234_5678; bus.pc_from_f = 32'h9ABC_DEF0;
    @(negedge clk);
    n_checks++; if (bus.PC !== 32'h8) begin n_fail++; $display("FAIL pcs11_hold: got %h want %h", bus.PC, 32'h8); end
    n_checks++; if (bus.misalign_err !== 1'b0) begin n_fail++; $display("FAIL merr_pre: got %b want 0", bus.misalign_err); end
    bus.pc_s = 2'b01; bus.pc_from_b = 32'h0000_0101;
    @(negedge clk);
    bus.write_pc = 1'b0;
    n_checks++; if (bus.PC !== 32'h100) begin n_fail++; $display("FAIL bx_pc: got %h want %h", bus.PC, 32'h100); end
    n_checks++; if (bus.misalign_err !== 1'b1) begin n_fail++; $display("FAIL bx_merr: got %b want 1", bus.misalign_err); end
    sb_q.push_back(exp_t'{ir: 32'h100 ^ salt, pc: 32'h104});
    lat_cfg = 1; bus.write_ir = 1'b1;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      if (bus.imem_req && !got_addr) begin got_addr = 1'b1; a1 = bus.imem_addr; end
      if (bus.W_IR_valid) begin
        seen = 1'b1; bus.write_ir = 1'b0;
        e = sb_q.pop_front();
        n_checks++; if (bus.IR !== e.ir) begin n_fail++; $display("FAIL bx_ir: got %h want %h", bus.IR, e.ir); end
        n_checks++; if (bus.PC !== e.pc) begin n_fail++; $display("FAIL bx_next_pc: got %h want %h", bus.PC, e.pc); end
      end
    end
    n_checks++; if (a1 !== 32'h100) begin n_fail++; $display("FAIL bx_fetch_addr: got %h want %h", a1, 32'h100); end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL bx_timeout: got no valid want one"); end
  endtask

  task automatic test_redirect_in_req();
    int rises = 0; int first_cycles = 0; int valids = 0; bit prev_req = 1'b0;
    bit redirected = 1'b0; bit pc_checked = 1'b0; logic [31:0] a2 = 32'hX; exp_t e;
    @(negedge clk);
    sb_q.push_back(exp_t'{ir: 32'h40 ^ salt, pc: 32'h44});
    lat_cfg = 3; bus.write_ir = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      bus.write_pc = 1'b0;
      if (bus.imem_req && !prev_req) begin rises++; if (rises == 2) a2 = bus.imem_addr; end
      if (bus.imem_req && rises == 1) first_cycles++;
      if (redirected && !pc_checked) begin
        pc_checked = 1'b1;
        n_checks++; if (bus.PC !== 32'h40) begin n_fail++; $display("FAIL rreq_pc: got %h want %h", bus.PC, 32'h40); end
      end
      if (rises == 1 && first_cycles == 1 && !redirected) begin
        redirected = 1'b1; bus.write_pc = 1'b1; bus.pc_s = 2'b10; bus.pc_from_f = 32'h40;
      end
      prev_req = bus.imem_req;
      if (bus.W_IR_valid) begin
        valids++; bus.write_ir = 1'b0;
        if (sb_q.size() == 0) begin
          n_checks++; n_fail++; $display("FAIL rreq_extra_valid: got valid want none");
        end else begin
          e = sb_q.pop_front();
          n_checks++; if (bus.IR !== e.ir) begin n_fail++; $display("FAIL rreq_ir: got %h want %h", bus.IR, e.ir); end
          n_checks++; if (bus.PC !== e.pc) begin n_fail++; $display("FAIL rreq_pc_after: got %h want %h", bus.PC, e.pc); end
        end
      end
    end
    n_checks++; if (valids != 1) begin n_fail++; $display("FAIL rreq_valid_count: got %0d want 1", valids); end
    n_checks++; if (first_cycles != 4) begin n_fail++; $display("FAIL rreq_req_held: got %0d want 4", first_cycles); end
    n_checks++; if (a2 !== 32'h40) begin n_fail++; $display("FAIL rreq_next_addr: got %h want %h", a2, 32'h40); end
  endtask

  task automatic test_redirect_on_ack();
    int reqc = 0; int valids = 0;
    @(negedge clk);
    lat_cfg = 2; bus.write_ir = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      bus.write_pc = 1'b0;
      if (bus.imem_req) begin
        reqc++;
        if (reqc == 3) begin
          bus.write_pc = 1'b1; bus.pc_s = 2'b01; bus.pc_from_b = 32'h200; bus.write_ir = 1'b0;
        end
      end
      if (bus.W_IR_valid) valids++;
    end
    n_checks++; if (valids != 0) begin n_fail++; $display("FAIL rack_valid: got %0d want 0", valids); end
    n_checks++; if (bus.PC !== 32'h200) begin n_fail++; $display("FAIL rack_pc: got %h want %h", bus.PC, 32'h200); end
    n_checks++; if (bus.IR !== (32'h40 ^ salt)) begin n_fail++; $display("FAIL rack_ir_kept: got %h want %h", bus.IR, 32'h40 ^ salt); end
    n_checks++; if (reqc != 3) begin n_fail++; $display("FAIL rack_req_cycles: got %0d want 3", reqc); end
  endtask

  task automatic test_timeout();
    int rises = 0; int c1 = 0; bit prev_req = 1'b0; bit seen = 1'b0; bit dropped = 1'b0;
    logic [31:0] a1 = 32'hX; logic [31:0] a2 = 32'hX; exp_t e;
    @(negedge clk);
    sb_q.push_back(exp_t'{ir: 32'h200 ^ salt, pc: 32'h204});
    lat_cfg = -1; bus.write_ir = 1'b1;
    for (int k = 1; k <= 60 && !seen; k++) begin
      @(negedge clk);
      if (bus.imem_req && !prev_req) begin
        rises++;
        if (rises == 1) a1 = bus.imem_addr; else if (rises == 2) a2 = bus.imem_addr;
      end
      if (bus.imem_req && rises == 1) begin
        c1++;
        if (c1 == 1) begin
          n_checks++; if (bus.fetch_err !== 1'b0) begin n_fail++; $display("FAIL to_ferr_early: got %b want 0", bus.fetch_err); end
        end
      end
      if (!bus.imem_req && prev_req && rises == 1 && !dropped) begin
        dropped = 1'b1; lat_cfg = 0;
        n_checks++; if (bus.fetch_err !== 1'b1) begin n_fail++; $display("FAIL to_ferr: got %b want 1", bus.fetch_err); end
      end
      prev_req = bus.imem_req;
      if (bus.W_IR_valid) begin
        seen = 1'b1; bus.write_ir = 1'b0;
        e = sb_q.pop_front();
        n_checks++; if (bus.IR !== e.ir) begin n_fail++; $display("FAIL to_retry_ir: got %h want %h", bus.IR, e.ir); end
        n_checks++; if (bus.PC !== e.pc) begin n_fail++; $display("FAIL to_retry_pc: got %h want %h", bus.PC, e.pc); end
      end
    end
    n_checks++; if (c1 != 15) begin n_fail++; $display("FAIL to_req_cycles: got %0d want 15", c1); end
    n_checks++; if (a1 !== 32'h200 || a2 !== 32'h200) begin n_fail++; $display("FAIL to_retry_addr: got %h/%h want 00000200", a1, a2); end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL to_no_retry: got no valid want one"); end
  endtask

  task automatic test_back_to_back();
    int times[3]; int nv = 0; exp_t e;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(exp_t'{ir: (32'h204 + 32'(4 * i)) ^ salt, pc: 32'h208 + 32'(4 * i)});
    end
    lat_cfg = 0; bus.write_ir = 1'b1;
    for (int k = 1; k <= 30 && nv < 3; k++) begin
      @(negedge clk);
      if (bus.W_IR_valid) begin
        times[nv] = k; nv++;
        if (nv == 3) bus.write_ir = 1'b0;
        e = sb_q.pop_front();
        n_checks++; if (bus.IR !== e.ir) begin n_fail++; $display("FAIL b2b_ir%0d: got %h want %h", nv, bus.IR, e.ir); end
        n_checks++; if (bus.PC !== e.pc) begin n_fail++; $display("FAIL b2b_pc%0d: got %h want %h", nv, bus.PC, e.pc); end
      end
    end
    n_checks++;
    if (nv != 3 || times[1] - times[0] != 3 || times[2] - times[1] != 3) begin
      n_fail++; $display("FAIL b2b_spacing: got %0d pulses at %0d,%0d,%0d want 3 pulses 3 apart", nv, times[0], times[1], times[2]);
    end
  endtask

  task automatic test_wrap();
    bit seen = 1'b0; logic [31:0] a1 = 32'hX; exp_t e;
    @(negedge clk);
    bus.write_pc = 1'b1; bus.pc_s = 2'b10; bus.pc_from_f = 32'hFFFF_FFFC;
    @(negedge clk);
    bus.write_pc = 1'b0;
    sb_q.push_back(exp_t'{ir: 32'hFFFF_FFFC ^ salt, pc: 32'h0});
    lat_cfg = 0; bus.write_ir = 1'b1;
    for (int k = 1; k <= 10 && !seen; k++) begin
      @(negedge clk);
      if (bus.imem_req) a1 = bus.imem_addr;
      if (bus.W_IR_valid) begin
        seen = 1'b1; bus.write_ir = 1'b0;
        e = sb_q.pop_front();
        n_checks++; if (bus.IR !== e.ir) begin n_fail++; $display("FAIL wrap_ir: got %h want %h", bus.IR, e.ir); end
        n_checks++; if (bus.PC !== e.pc) begin n_fail++; $display("FAIL wrap_pc: got %h want %h", bus.PC, e.pc); end
      end
    end
    n_checks++; if (a1 !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr: got %h want FFFFFFFC", a1); end
  endtask

  task automatic test_reset_mid_req();
    int valids = 0; bit seen = 1'b0; exp_t e;
    @(negedge clk);
    lat_cfg = -1; bus.write_ir = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rmid_req_async: got %b want 0", bus.imem_req); end
    n_checks++;
    if ({bus.PC, bus.IR, bus.fetch_err, bus.misalign_err} !== 66'd0) begin
      n_fail++; $display("FAIL rmid_state: pc=%h ir=%h ferr=%b merr=%b want 0", bus.PC, bus.IR, bus.fetch_err, bus.misalign_err);
    end
    @(negedge clk);
    rst = 1'b0; bus.write_ir = 1'b0; ack_force = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 3) ack_force = 1'b0;
      if (bus.W_IR_valid) valids++;
    end
    n_checks++; if (valids != 0 || bus.IR !== 32'd0) begin n_fail++; $display("FAIL rmid_idle_ack: got %0d valids ir=%h want 0", valids, bus.IR); end
    sb_q.push_back(exp_t'{ir: salt, pc: 32'h4});
    lat_cfg = 0; bus.write_ir = 1'b1;
    for (int k = 1; k <= 10 && !seen; k++) begin
      @(negedge clk);
      if (bus.W_IR_valid) begin
        seen = 1'b1; bus.write_ir = 1'b0;
        e = sb_q.pop_front();
        n_checks++; if (bus.IR !== e.ir || bus.PC !== e.pc) begin
          n_fail++; $display("FAIL rmid_refetch: got ir=%h pc=%h want ir=%h pc=%h", bus.IR, bus.PC, e.ir, e.pc);
        end
      end
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL rmid_no_refetch: got no valid want one"); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_latency();
    test_bx_redirect();
    test_redirect_in_req();
    test_redirect_on_ack();
    test_timeout();
    test_back_to_back();
    test_wrap();
    test_reset_mid_req();
    n_checks++;
    if (sb_q.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d entries want 0", sb_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
